// File: rtl/north_i_router.sv
// North pad input router: synchronizes the asynchronous pad bus and steers it to the
// selected macro, with a guarded handover whenever the selection changes.
module north_i_router #(
  parameter int WIDTH        = 10,
  parameter int SYNC_STAGES  = 2,
  parameter int GUARD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       configuration,
  input  logic [WIDTH-1:0] north_i_0,
  output logic [WIDTH-1:0] north_i_buf_0,
  output logic [WIDTH-1:0] north_i_buf_1,
  output logic [WIDTH-1:0] north_i_buf_2,
  output logic [WIDTH-1:0] north_i_buf_3,
  output logic [WIDTH-1:0] north_i_edge,
  output logic [3:0]       north_i_valid,
  output logic             switch_busy
);

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GUARD  = 2'd2
  } state_t;

  localparam logic [8:0] RESET_CNT = 9'(SYNC_STAGES + GUARD_CYCLES);
  localparam logic [8:0] GUARD_CNT = 9'(GUARD_CYCLES);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
  logic [WIDTH-1:0]                  sync_q_s;
  logic [WIDTH-1:0]                  prev_r;
  logic [1:0]                        sel_map_s;

  state_t     state_r, state_nxt_s;
  logic [8:0] cnt_r, cnt_nxt_s;
  logic [1:0] active_sel_r, active_sel_nxt_s;
  logic [1:0] last_sel_r, last_sel_nxt_s;
  logic       go_active_s;

  logic [3:0][WIDTH-1:0] buf_r, buf_nxt_s;
  logic [WIDTH-1:0]      edge_r, edge_nxt_s;
  logic [3:0]            valid_r, valid_nxt_s;
  logic                  busy_r, busy_nxt_s;

  // Pad synchronizer chain and previous-value register, running in every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
      prev_r <= '0;
    end else begin
      sync_r[0] <= north_i_0;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      prev_r <= sync_q_s;
    end
  end

  assign sync_q_s = sync_r[SYNC_STAGES-1];

  // Out-of-range selections alias to macro 0
  always_comb begin
    if (configuration[3:2] == 2'b00) begin
      sel_map_s = configuration[1:0];
    end else begin
      sel_map_s = 2'b00;
    end
  end

  // Handover sequencing: next state, counter and selection
  always_comb begin
    state_nxt_s      = state_r;
    cnt_nxt_s        = cnt_r;
    active_sel_nxt_s = active_sel_r;
    last_sel_nxt_s   = last_sel_r;
    go_active_s      = 1'b0;
    case (state_r)
      ST_SETTLE: begin
        if (cnt_r <= 9'd1) begin
          state_nxt_s      = ST_ACTIVE;
          active_sel_nxt_s = sel_map_s;
          go_active_s      = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - 9'd1;
        end
      end
      ST_ACTIVE: begin
        if (sel_map_s != active_sel_r) begin
          state_nxt_s    = ST_GUARD;
          cnt_nxt_s      = GUARD_CNT;
          last_sel_nxt_s = sel_map_s;
        end else begin
          go_active_s = 1'b1;
        end
      end
      ST_GUARD: begin
        // A fresh selection change restarts the whole guard interval
        if (sel_map_s != last_sel_r) begin
          cnt_nxt_s      = GUARD_CNT;
          last_sel_nxt_s = sel_map_s;
        end else if (cnt_r <= 9'd1) begin
          state_nxt_s      = ST_ACTIVE;
          active_sel_nxt_s = sel_map_s;
          go_active_s      = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - 9'd1;
        end
      end
      default: begin
        state_nxt_s = ST_SETTLE;
        cnt_nxt_s   = RESET_CNT;
      end
    endcase
  end

  // Output values for the next cycle; everything is quiet unless routing is live
  always_comb begin
    buf_nxt_s   = '0;
    edge_nxt_s  = '0;
    valid_nxt_s = 4'b0000;
    busy_nxt_s  = 1'b1;
    if (go_active_s) begin
      buf_nxt_s[active_sel_nxt_s] = sync_q_s;
      edge_nxt_s                  = sync_q_s ^ prev_r;
      valid_nxt_s                 = 4'b0001 << active_sel_nxt_s;
      busy_nxt_s                  = 1'b0;
    end else begin
      busy_nxt_s = 1'b1;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_SETTLE;
      cnt_r        <= RESET_CNT;
      active_sel_r <= 2'b00;
      last_sel_r   <= 2'b00;
      buf_r        <= '0;
      edge_r       <= '0;
      valid_r      <= 4'b0000;
      busy_r       <= 1'b1;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      active_sel_r <= active_sel_nxt_s;
      last_sel_r   <= last_sel_nxt_s;
      buf_r        <= buf_nxt_s;
      edge_r       <= edge_nxt_s;
      valid_r      <= valid_nxt_s;
      busy_r       <= busy_nxt_s;
    end
  end

  assign north_i_buf_0 = buf_r[0];
  assign north_i_buf_1 = buf_r[1];
  assign north_i_buf_2 = buf_r[2];
  assign north_i_buf_3 = buf_r[3];
  assign north_i_edge  = edge_r;
  assign north_i_valid = valid_r;
  assign switch_busy   = busy_r;

endmodule

// File: tb/tb_north_i_router.sv
// Directed testbench for north_i_router: reset sequencing, latency, edge strobes,
// guarded handover, aliasing of out-of-range configurations and mid-run reset.
module tb_north_i_router;

  logic       clk;
  logic       rst_n;
  logic [3:0] configuration;
  logic [9:0] north_i_0;
  logic [9:0] north_i_buf_0, north_i_buf_1, north_i_buf_2, north_i_buf_3;
  logic [9:0] north_i_edge;
  logic [3:0] north_i_valid;
  logic       switch_busy;

  int tests_run = 0;
  int tests_failed = 0;

  north_i_router #(.WIDTH(10), .SYNC_STAGES(2), .GUARD_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .configuration(configuration), .north_i_0(north_i_0),
    .north_i_buf_0(north_i_buf_0), .north_i_buf_1(north_i_buf_1),
    .north_i_buf_2(north_i_buf_2), .north_i_buf_3(north_i_buf_3),
    .north_i_edge(north_i_edge), .north_i_valid(north_i_valid), .switch_busy(switch_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits one cycle for busy to rise, then up to 30 cycles for it to fall.
  task automatic wait_not_busy(output bit timed_out);
    timed_out = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      if (switch_busy === 1'b0) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Reset release with config 2 and pad 0x155: 6 busy cycles, then macro 2 live.
  task automatic test_reset(input logic [9:0] pad);
    rst_n = 1'b0;
    configuration = 4'd2;
    north_i_0 = pad;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({north_i_buf_0, north_i_buf_1, north_i_buf_2, north_i_buf_3, north_i_edge} !== 50'd0 ||
        north_i_valid !== 4'b0000 || switch_busy !== 1'b1) begin
      $display("FAIL reset_values: valid=%b busy=%b buf2=%h", north_i_valid, switch_busy, north_i_buf_2);
      tests_failed++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (switch_busy !== 1'b1 || north_i_valid !== 4'b0000 || north_i_buf_2 !== 10'h000) begin
        $display("FAIL settle_busy[%0d]: busy=%b valid=%b buf2=%h want busy=1 valid=0000 buf2=000",
                 i, switch_busy, north_i_valid, north_i_buf_2);
        tests_failed++;
      end
      @(negedge clk);
    end
    tests_run++;
    if (north_i_buf_2 !== pad || north_i_valid !== 4'b0100 || switch_busy !== 1'b0 ||
        north_i_buf_0 !== 10'h000 || north_i_buf_1 !== 10'h000 || north_i_buf_3 !== 10'h000) begin
      $display("FAIL settle_active: buf2=%h valid=%b busy=%b want buf2=%h valid=0100 busy=0",
               north_i_buf_2, north_i_valid, switch_busy, pad);
      tests_failed++;
    end
    tests_run++;
    if (north_i_edge !== 10'h000) begin
      $display("FAIL first_active_edge: edge=%h want 000", north_i_edge);
      tests_failed++;
    end
  endtask

  // Macro 1 active, pad steps 0x000 -> 0x3FF: 3-cycle latency and a one-cycle edge pulse.
  task automatic test_step;
    bit to;
    north_i_0 = 10'h000;
    configuration = 4'd1;
    wait_not_busy(to);
    tests_run++;
    if (to) begin
      $display("FAIL step_wait: busy never cleared");
      tests_failed++;
    end
    repeat (4) @(negedge clk);
    tests_run++;
    if (north_i_valid !== 4'b0010 || north_i_buf_1 !== 10'h000) begin
      $display("FAIL step_pre: valid=%b buf1=%h want 0010 000", north_i_valid, north_i_buf_1);
      tests_failed++;
    end
    north_i_0 = 10'h3FF;
    repeat (2) @(negedge clk);
    tests_run++;
    if (north_i_buf_1 !== 10'h000 || north_i_edge !== 10'h000) begin
      $display("FAIL step_early: buf1=%h edge=%h want 000 000", north_i_buf_1, north_i_edge);
      tests_failed++;
    end
    @(negedge clk);
    tests_run++;
    if (north_i_buf_1 !== 10'h3FF || north_i_edge !== 10'h3FF) begin
      $display("FAIL step_latency: buf1=%h edge=%h want 3ff 3ff", north_i_buf_1, north_i_edge);
      tests_failed++;
    end
    @(negedge clk);
    tests_run++;
    if (north_i_buf_1 !== 10'h3FF || north_i_edge !== 10'h000) begin
      $display("FAIL step_pulse_width: buf1=%h edge=%h want 3ff 000", north_i_buf_1, north_i_edge);
      tests_failed++;
    end
  endtask

  // Config 1 -> 3: outputs blank next cycle, 4 busy cycles, then macro 3 tracks the pad.
  task automatic test_switch;
    configuration = 4'd3;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      tests_run++;
      if (switch_busy !== 1'b1 || north_i_valid !== 4'b0000 || north_i_edge !== 10'h000 ||
          {north_i_buf_0, north_i_buf_1, north_i_buf_2, north_i_buf_3} !== 40'd0) begin
        $display("FAIL switch_guard[%0d]: busy=%b valid=%b buf1=%h buf3=%h want busy=1 all 0",
                 i, switch_busy, north_i_valid, north_i_buf_1, north_i_buf_3);
        tests_failed++;
      end
    end
    @(negedge clk);
    tests_run++;
    if (switch_busy !== 1'b0 || north_i_valid !== 4'b1000 || north_i_buf_3 !== 10'h3FF ||
        north_i_buf_1 !== 10'h000) begin
      $display("FAIL switch_done: busy=%b valid=%b buf3=%h buf1=%h want 0 1000 3ff 000",
               switch_busy, north_i_valid, north_i_buf_3, north_i_buf_1);
      tests_failed++;
    end
    north_i_0 = 10'h155;
    repeat (3) @(negedge clk);
    tests_run++;
    if (north_i_buf_3 !== 10'h155 || north_i_buf_1 !== 10'h000) begin
      $display("FAIL switch_track: buf3=%h buf1=%h want 155 000", north_i_buf_3, north_i_buf_1);
      tests_failed++;
    end
  endtask

  // Config 0 -> 4 -> 9 maps to macro 0 throughout: no guard, buffer uninterrupted.
  task automatic test_alias;
    bit to;
    configuration = 4'd0;
    wait_not_busy(to);
    tests_run++;
    if (to) begin
      $display("FAIL alias_wait: busy never cleared");
      tests_failed++;
    end
    configuration = 4'd4;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (switch_busy !== 1'b0 || north_i_valid !== 4'b0001 || north_i_buf_0 !== 10'h155) begin
        $display("FAIL alias_4[%0d]: busy=%b valid=%b buf0=%h want 0 0001 155",
                 i, switch_busy, north_i_valid, north_i_buf_0);
        tests_failed++;
      end
    end
    configuration = 4'd9;
    north_i_0 = 10'h0AA;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (switch_busy !== 1'b0 || north_i_valid !== 4'b0001 ||
          north_i_buf_0 !== ((i < 3) ? 10'h155 : 10'h0AA)) begin
        $display("FAIL alias_9[%0d]: busy=%b valid=%b buf0=%h", i, switch_busy, north_i_valid, north_i_buf_0);
        tests_failed++;
      end
    end
  endtask

  // Config 0 -> 2, then 2 -> 1 two cycles into guard: counter reloads, 6 busy cycles total.
  task automatic test_reload;
    configuration = 4'd2;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 2) configuration = 4'd1;
      tests_run++;
      if (switch_busy !== 1'b1 || north_i_valid !== 4'b0000 || north_i_buf_2 !== 10'h000) begin
        $display("FAIL reload_guard[%0d]: busy=%b valid=%b buf2=%h want 1 0000 000",
                 i, switch_busy, north_i_valid, north_i_buf_2);
        tests_failed++;
      end
    end
    @(negedge clk);
    tests_run++;
    if (switch_busy !== 1'b0 || north_i_valid !== 4'b0010 || north_i_buf_1 !== 10'h0AA ||
        north_i_buf_2 !== 10'h000) begin
      $display("FAIL reload_done: busy=%b valid=%b buf1=%h buf2=%h want 0 0010 0aa 000",
               switch_busy, north_i_valid, north_i_buf_1, north_i_buf_2);
      tests_failed++;
    end
  endtask

  // Asynchronous reset in ACTIVE with pad 0x2AA, then the settle sequence repeats.
  task automatic test_reset_mid;
    north_i_0 = 10'h2AA;
    repeat (4) @(negedge clk);
    tests_run++;
    if (north_i_buf_1 !== 10'h2AA) begin
      $display("FAIL mid_pre: buf1=%h want 2aa", north_i_buf_1);
      tests_failed++;
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({north_i_buf_0, north_i_buf_1, north_i_buf_2, north_i_buf_3, north_i_edge} !== 50'd0 ||
        north_i_valid !== 4'b0000 || switch_busy !== 1'b1) begin
      $display("FAIL mid_async: buf1=%h valid=%b busy=%b want 000 0000 1",
               north_i_buf_1, north_i_valid, switch_busy);
      tests_failed++;
    end
    test_reset(10'h2AA);
  endtask

  initial begin
    rst_n = 1'b0;
    configuration = 4'd0;
    north_i_0 = 10'h000;
    test_reset(10'h155);
    test_step();
    test_switch();
    test_alias();
    test_reload();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
